pwm_duty_sequencer: RTL and testbench



---
 rtl/pwm_seq_pkg.sv | 18 +
 rtl/pwm_duty_sequencer_duty_ramp.sv | 52 +++++
 rtl/pwm_duty_sequencer.sv | 141 ++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and defaults for the PWM duty sequencer.
// PWM_SEQ_SOFTSTOP_EN adds the STOPPING state to the encoding.
package pwm_seq_pkg;

  localparam int DW_DEFAULT   = 10;
  localparam int STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAMP     = 3'd1,
    RUN      = 3'd2,
`ifdef PWM_SEQ_SOFTSTOP_EN
    STOPPING = 3'd3,
`endif
    FAULT    = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_duty_sequencer_duty_ramp.sv
// Registered duty word that steps toward a target by STEP when enabled,
// clamping at the target so it never overshoots in either direction.
module duty_ramp
  import pwm_seq_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int STEP = STEP_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_en,
  input  logic          clr,
  input  logic [DW-1:0] tgt,
  output logic [DW-1:0] d,
  output logic          done
);

  localparam logic [DW:0] STEP_W = (DW+1)'(STEP);

  logic [DW:0]   d_w;
  logic [DW:0]   tgt_w;
  logic [DW:0]   up_sum;
  logic [DW:0]   dn_diff;
  logic [DW-1:0] d_step;

  // One extra bit keeps the carry/borrow visible so the clamp also covers
  // saturation at 0 and at full scale.
  always_comb begin
    d_w     = {1'b0, d};
    tgt_w   = {1'b0, tgt};
    up_sum  = d_w + STEP_W;
    dn_diff = d_w - STEP_W;
    d_step  = d;
    if (d_w < tgt_w) begin
      d_step = (up_sum >= tgt_w) ? tgt : up_sum[DW-1:0];
    end else if (d_w > tgt_w) begin
      d_step = (dn_diff[DW] || (dn_diff < tgt_w)) ? tgt : dn_diff[DW-1:0];
    end
    done = (d_step == tgt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
    end else if (clr) begin
      d <= '0;
    end else if (step_en) begin
      d <= d_step;
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Soft-start/soft-stop sequencer for the PWM duty word with latched fault shutdown.
// Define PWM_SEQ_SOFTSTOP_EN to ramp down on stop; otherwise stop cuts duty at once.
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] target,
  input  logic          fault,
  input  logic          fault_clr,
  output logic [DW-1:0] d,
  output logic          en,
  output logic          at_target,
  output logic          busy,
  output logic          fault_latched
);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] tgt_q;
  logic [DW-1:0] ramp_tgt;
  logic          latch;
  logic          step_en;
  logic          clr;
  logic          done;
  logic          busy_d;

  duty_ramp #(
    .DW   (DW),
    .STEP (STEP)
  ) u_ramp (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .clr     (clr),
    .tgt     (ramp_tgt),
    .d       (d),
    .done    (done)
  );

  // Kept apart from the next-state logic so the ramp's done flag never
  // loops back into its own target select.
  always_comb begin
    latch    = 1'b0;
    ramp_tgt = tgt_q;
    if (!fault && !stop && tick && ((state_q == RAMP) || (state_q == RUN))) begin
      latch    = 1'b1;
      ramp_tgt = target;
    end
`ifdef PWM_SEQ_SOFTSTOP_EN
    if (state_q == STOPPING) begin
      ramp_tgt = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    clr     = 1'b0;
    if (fault) begin
      state_d = FAULT;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) state_d = RAMP;
        end
        RAMP, RUN: begin
          if (stop) begin
`ifdef PWM_SEQ_SOFTSTOP_EN
            state_d = STOPPING;
`else
            state_d = IDLE;
            clr     = 1'b1;
`endif
          end else if (tick) begin
            if (state_q == RAMP) begin
              step_en = 1'b1;
              if (done) state_d = RUN;
            end else if (target != d) begin
              state_d = RAMP;
            end
          end
        end
`ifdef PWM_SEQ_SOFTSTOP_EN
        STOPPING: begin
          if (start && !stop) begin
            state_d = RAMP;
          end else if (d == '0) begin
            state_d = IDLE;
          end else if (tick) begin
            step_en = 1'b1;
          end
        end
`endif
        FAULT: begin
          if (fault_clr) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == RAMP);
`ifdef PWM_SEQ_SOFTSTOP_EN
    busy_d = busy_d || (state_d == STOPPING);
`endif
  end

  // Status outputs are registered from the next state so they switch on
  // the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      en            <= 1'b0;
      at_target     <= 1'b0;
      busy          <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (latch) tgt_q <= target;
      en            <= (state_d != IDLE) && (state_d != FAULT);
      at_target     <= (state_d == RUN);
      busy          <= busy_d;
      fault_latched <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Table-driven bench for pwm_duty_sequencer (STEP=4, DW=10); expected outputs
// travel through a queue from the driving side to the checking side.
module tb_pwm_duty_sequencer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       start;
  logic       stop;
  logic [9:0] target;
  logic       fault;
  logic       fault_clr;
  logic [9:0] d;
  logic       en;
  logic       at_target;
  logic       busy;
  logic       fault_latched;

  typedef struct {
    string       name;
    logic        tick;
    logic        start;
    logic        stop;
    logic        fault;
    logic        fault_clr;
    logic [9:0]  target;
    logic [13:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;

  pwm_duty_sequencer #(
    .STEP (4),
    .DW   (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .start         (start),
    .stop          (stop),
    .target        (target),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .d             (d),
    .en            (en),
    .at_target     (at_target),
    .busy          (busy),
    .fault_latched (fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic tk, input logic st,
                              input logic sp, input logic ft, input logic fc,
                              input int tg, input int ed, input logic een,
                              input logic eat, input logic ebusy, input logic efl);
    vec_t v;
    v.name      = n;
    v.tick      = tk;
    v.start     = st;
    v.stop      = sp;
    v.fault     = ft;
    v.fault_clr = fc;
    v.target    = 10'(tg);
    v.exp       = {10'(ed), een, eat, ebusy, efl};
    return v;
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got d=%0d en=%b at_target=%b busy=%b fault_latched=%b, expected d=%0d en=%b at_target=%b busy=%b fault_latched=%b",
               name, got[13:4], got[3], got[2], got[1], got[0],
               exp[13:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [13:0] e;
    tick      = v.tick;
    start     = v.start;
    stop      = v.stop;
    fault     = v.fault;
    fault_clr = v.fault_clr;
    target    = v.target;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(v.name, {d, en, at_target, busy, fault_latched}, e);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    tick      = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    target    = '0;
    fault     = 1'b0;
    fault_clr = 1'b0;

    //           name           tk st sp ft fc  tgt   d  en at bz fl
    vecs.push_back(mk("start",     0, 1, 0, 0, 0,  20,   0, 1, 0, 1, 0));
    vecs.push_back(mk("up_t1",     1, 0, 0, 0, 0,  20,   4, 1, 0, 1, 0));
    vecs.push_back(mk("hold_t1",   0, 0, 0, 0, 0,  20,   4, 1, 0, 1, 0));
    vecs.push_back(mk("up_t2",     1, 0, 0, 0, 0,  20,   8, 1, 0, 1, 0));
    vecs.push_back(mk("up_t3",     1, 0, 0, 0, 0,  20,  12, 1, 0, 1, 0));
    vecs.push_back(mk("up_t4",     1, 0, 0, 0, 0,  20,  16, 1, 0, 1, 0));
    vecs.push_back(mk("up_t5",     1, 0, 0, 0, 0,  20,  20, 1, 1, 0, 0));
    vecs.push_back(mk("run_hold",  0, 0, 0, 0, 0,  20,  20, 1, 1, 0, 0));
    vecs.push_back(mk("retgt22",   1, 0, 0, 0, 0,  22,  20, 1, 0, 1, 0));
    vecs.push_back(mk("clamp22",   1, 0, 0, 0, 0,  22,  22, 1, 1, 0, 0));
    vecs.push_back(mk("retgt10",   1, 0, 0, 0, 0,  10,  22, 1, 0, 1, 0));
    vecs.push_back(mk("dn_18",     1, 0, 0, 0, 0,  10,  18, 1, 0, 1, 0));
    vecs.push_back(mk("dn_14",     1, 0, 0, 0, 0,  10,  14, 1, 0, 1, 0));
    vecs.push_back(mk("dn_10",     1, 0, 0, 0, 0,  10,  10, 1, 1, 0, 0));
`ifdef PWM_SEQ_SOFTSTOP_EN
    vecs.push_back(mk("stop",      0, 0, 1, 0, 0,  10,  10, 1, 0, 1, 0));
    vecs.push_back(mk("soft_6",    1, 0, 0, 0, 0,  10,   6, 1, 0, 1, 0));
    vecs.push_back(mk("soft_2",    1, 0, 0, 0, 0,  10,   2, 1, 0, 1, 0));
    vecs.push_back(mk("soft_0",    1, 0, 0, 0, 0,  10,   0, 1, 0, 1, 0));
    vecs.push_back(mk("soft_idle", 0, 0, 0, 0, 0,  10,   0, 0, 0, 0, 0));
`else
    vecs.push_back(mk("stop",      0, 0, 1, 0, 0,  10,   0, 0, 0, 0, 0));
    vecs.push_back(mk("stop_idle", 1, 0, 0, 0, 0,  10,   0, 0, 0, 0, 0));
`endif
    vecs.push_back(mk("start_stop",0, 1, 1, 0, 0,  10,   0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_tick", 1, 0, 0, 0, 0,   5,   0, 0, 0, 0, 0));
    vecs.push_back(mk("start_t0",  0, 1, 0, 0, 0,   0,   0, 1, 0, 1, 0));
    vecs.push_back(mk("t0_run",    1, 0, 0, 0, 0,   0,   0, 1, 1, 0, 0));
    vecs.push_back(mk("retgt100",  1, 0, 0, 0, 0, 100,   0, 1, 0, 1, 0));
    vecs.push_back(mk("r100_4",    1, 0, 0, 0, 0, 100,   4, 1, 0, 1, 0));
    vecs.push_back(mk("r100_hold", 0, 0, 0, 0, 0, 100,   4, 1, 0, 1, 0));
    vecs.push_back(mk("r100_8",    1, 0, 0, 0, 0, 100,   8, 1, 0, 1, 0));
    vecs.push_back(mk("fault",     0, 0, 0, 1, 0, 100,   0, 0, 0, 0, 1));
    vecs.push_back(mk("flt_start", 1, 1, 0, 1, 0, 100,   0, 0, 0, 0, 1));
    vecs.push_back(mk("flt_clr_hi",0, 0, 0, 1, 1, 100,   0, 0, 0, 0, 1));
    vecs.push_back(mk("flt_start2",1, 1, 0, 0, 0, 100,   0, 0, 0, 0, 1));
    vecs.push_back(mk("flt_clr",   0, 0, 0, 0, 1, 100,   0, 0, 0, 0, 0));
    vecs.push_back(mk("post_clr",  1, 0, 0, 0, 0, 100,   0, 0, 0, 0, 0));
    vecs.push_back(mk("rs_start",  0, 1, 0, 0, 0, 100,   0, 1, 0, 1, 0));
    for (int i = 1; i <= 4; i++) begin
      vecs.push_back(mk("rs_ramp",  1, 0, 0, 0, 0, 100, 4*i, 1, 0, 1, 0));
    end

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_vals", {d, en, at_target, busy, fault_latched}, 14'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle, with d at 16 mid-ramp.
    tick = 1'b0;
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {d, en, at_target, busy, fault_latched}, 14'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    run_vec(mk("rst_idle1", 1, 0, 0, 0, 0, 50, 0, 0, 0, 0, 0));
    run_vec(mk("rst_idle2", 1, 0, 0, 0, 0, 50, 0, 0, 0, 0, 0));
    run_vec(mk("rst_start", 0, 1, 0, 0, 0, 50, 0, 1, 0, 1, 0));
    run_vec(mk("rst_up4",   1, 0, 0, 0, 0, 50, 4, 1, 0, 1, 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
